// File: rtl/data_pack_pkg.sv
// Shared definitions for the symbol packer and its unpack partner.
package data_pack_pkg;

  localparam int unsigned SYM_W  = 7;
  localparam int unsigned WORD_W = 32;
  // Largest fill after one symbol is 31 + 7 = 38 bits.
  localparam int unsigned ACC_W  = WORD_W + SYM_W - 1;
  localparam int unsigned CNT_W  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // One output beat of the 32-bit link.
  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              sop;
    logic              eop;
  } word_t;

  // Fill count after one more symbol has been written.
  function automatic logic [CNT_W-1:0] fill_after(input logic [CNT_W-1:0] f);
    return f + CNT_W'(SYM_W);
  endfunction

endpackage

// File: rtl/data_pack_out_reg.sv
// One-entry valid/ready holding register for a packed output word.
module stream_out_reg
  import data_pack_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  word_t load_word,
  input  logic  take,
  output logic  valid,
  output word_t word,
  output logic  free_c
);

  // Entry can be refilled when empty or being drained this cycle.
  assign free_c = ~valid | take;

  // Hold the word until the link takes it; a load wins over a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      word  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      word  <= load_word;
    end else if (take) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/data_pack.sv
// Packs a 7-bit symbol stream LSB-first into 32-bit words with sop/eop framing.
module data_pack
  import data_pack_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic              ready_out,
  input  logic              valid_in,
  input  logic [SYM_W-1:0]  data_in,
  input  logic              sop_in,
  input  logic              eop_in,
  output logic              valid_out,
  output logic [WORD_W-1:0] data_out,
  output logic              sop_out,
  output logic              eop_out,
  input  logic              ready_in,
  output logic              sop_err
);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_ins;
  logic [CNT_W-1:0]   fill_q, fill_d, fill_sum;
  logic               first_q, first_d;
  logic               err_d;
  logic               accept, pack, sop_w, free_c, load;
  word_t              load_word, word;

  // Symbol handshake; FLUSH blocks input while the residue is emitted.
  assign ready_out = (state_q != FLUSH) & free_c & ~rst;
  assign accept    = valid_in & ready_out;
  assign pack      = accept & ((state_q == ACC) | ((state_q == IDLE) & sop_in));

  // Accumulator with the incoming symbol dropped in at the current fill.
  assign acc_ins   = acc_q | (ACC_W'(data_in) << fill_q);
  assign fill_sum  = fill_after(fill_q);
  assign sop_w     = (state_q == IDLE) | first_q;

  // State, accumulator and sop-tracking registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      fill_q  <= '0;
      first_q <= 1'b0;
      sop_err <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      first_q <= first_d;
      sop_err <= err_d;
    end
  end

  // Next-state, accumulator update and word generation.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    fill_d    = fill_q;
    first_d   = first_q;
    err_d     = 1'b0;
    load      = 1'b0;
    load_word = '0;

    case (state_q)
      IDLE: begin
        if (accept && !sop_in) begin
          err_d = 1'b1;
        end
      end
      ACC: begin
      end
      FLUSH: begin
        if (free_c) begin
          load           = 1'b1;
          load_word.data = acc_q[WORD_W-1:0];
          load_word.sop  = first_q;
          load_word.eop  = 1'b1;
          acc_d          = '0;
          fill_d         = '0;
          first_d        = 1'b0;
          state_d        = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (pack) begin
      load_word.data = acc_ins[WORD_W-1:0];
      load_word.sop  = sop_w;
      if (eop_in && (fill_sum <= CNT_W'(WORD_W))) begin
        // Packet ends inside this word: bits above the fill are already zero.
        load          = 1'b1;
        load_word.eop = 1'b1;
        acc_d         = '0;
        fill_d        = '0;
        first_d       = 1'b0;
        state_d       = IDLE;
      end else if (fill_sum >= CNT_W'(WORD_W)) begin
        // Full word out; any residue stays in the low bits.
        load          = 1'b1;
        load_word.eop = 1'b0;
        acc_d         = acc_ins >> WORD_W;
        fill_d        = fill_sum - CNT_W'(WORD_W);
        first_d       = 1'b0;
        state_d       = eop_in ? FLUSH : ACC;
      end else begin
        acc_d   = acc_ins;
        fill_d  = fill_sum;
        first_d = sop_w;
        state_d = ACC;
      end
    end
  end

  stream_out_reg u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_word (load_word),
    .take      (ready_in),
    .valid     (valid_out),
    .word      (word),
    .free_c    (free_c)
  );

  assign data_out = word.data;
  assign sop_out  = word.sop;
  assign eop_out  = word.eop;

endmodule

// File: tb/tb_data_pack.sv
// Randomised self-checking bench for data_pack against a bit-stream model.
module tb_data_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready_out;
  logic        valid_in = 1'b0;
  logic [6:0]  data_in = '0;
  logic        sop_in = 1'b0;
  logic        eop_in = 1'b0;
  logic        valid_out;
  logic [31:0] data_out;
  logic        sop_out;
  logic        eop_out;
  logic        ready_in = 1'b1;
  logic        sop_err;

  data_pack dut (
    .clk       (clk),
    .rst       (rst),
    .ready_out (ready_out),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .sop_in    (sop_in),
    .eop_in    (eop_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .sop_out   (sop_out),
    .eop_out   (eop_out),
    .ready_in  (ready_in),
    .sop_err   (sop_err)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Behavioural model state.
  typedef struct { logic [31:0] d; logic s; logic e; } wd_t;
  wd_t  expq[$];
  bit   bits[$];
  bit   in_pkt = 0, first_w = 0;
  bit   err_exp = 0, lat_exp = 0, flush_owed = 0;
  bit   hold_prev = 0, rst_prev = 0, saw_block = 0;
  wd_t  hold_w;
  int   last_acc_cyc = 0;

  // Log of words taken by the link, for literal checks.
  logic [31:0] log_d[$];
  bit          log_s[$], log_e[$];
  int          log_c[$];

  // Stimulus controls for ready_in.
  bit rdy_rand = 0;
  bit rdy_val  = 1;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #2;
    ready_in = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
  end

  function automatic wd_t pop_word(input bit eop, input bit fill_ok);
    wd_t w;
    w.d = '0;
    for (int i = 0; i < 32; i++) begin
      if (bits.size() > 0) w.d[i] = bits.pop_front();
    end
    w.s = first_w;
    w.e = eop;
    return w;
  endfunction

  // Model reaction to one accepted symbol.
  task automatic model_accept(input logic [6:0] s, input bit so, input bit eo);
    int produced;
    wd_t w;
    produced = 0;
    last_acc_cyc = cyc;
    if (!in_pkt) begin
      if (!so) begin
        err_exp = 1;
        return;
      end
      in_pkt = 1;
      first_w = 1;
      bits.delete();
    end
    for (int b = 0; b < 7; b++) bits.push_back(s[b]);
    while (bits.size() >= 32) begin
      w = pop_word(0, 1);
      expq.push_back(w);
      first_w = 0;
      produced++;
    end
    if (eo) begin
      if (bits.size() == 0) begin
        expq[expq.size()-1].e = 1;
      end else begin
        if (produced > 0) flush_owed = 1;
        w = pop_word(1, 1);
        expq.push_back(w);
        produced++;
      end
      in_pkt = 0;
      first_w = 0;
    end
    if (produced > 0) lat_exp = 1;
  endtask

  // Compare process: checks DUT against the model every cycle.
  initial forever begin
    wd_t w;
    @(negedge clk);
    if (rst_prev) begin
      chk("rst_valid", 32'(valid_out), 32'd0);
      chk("rst_data", data_out, 32'd0);
      chk("rst_sop", 32'(sop_out), 32'd0);
      chk("rst_eop", 32'(eop_out), 32'd0);
    end
    chk("sop_err", 32'(sop_err), 32'(err_exp));
    err_exp = 0;
    if (lat_exp) chk("latency_valid", 32'(valid_out), 32'd1);
    lat_exp = 0;
    if (hold_prev) begin
      chk("hold_valid", 32'(valid_out), 32'd1);
      chk("hold_data", data_out, hold_w.d);
      chk("hold_sop", 32'(sop_out), 32'(hold_w.s));
      chk("hold_eop", 32'(eop_out), 32'(hold_w.e));
    end
    if (flush_owed && valid_out && eop_out) flush_owed = 0;
    chk("ready_out", 32'(ready_out), 32'(!rst && !flush_owed && (!valid_out || ready_in)));
    if (!rst && ready_in && !ready_out) saw_block = 1;
    if (rst) begin
      expq.delete();
      bits.delete();
      in_pkt = 0;
      first_w = 0;
      flush_owed = 0;
    end else begin
      if (valid_out && ready_in) begin
        log_d.push_back(data_out);
        log_s.push_back(sop_out);
        log_e.push_back(eop_out);
        log_c.push_back(cyc);
        if (expq.size() == 0) begin
          chk("unexpected_word", 32'(valid_out), 32'd0);
        end else begin
          w = expq.pop_front();
          chk("word_data", data_out, w.d);
          chk("word_sop", 32'(sop_out), 32'(w.s));
          chk("word_eop", 32'(eop_out), 32'(w.e));
        end
      end
      if (valid_in && ready_out) model_accept(data_in, sop_in, eop_in);
    end
    hold_prev = !rst && valid_out && !ready_in;
    hold_w.d = data_out;
    hold_w.s = sop_out;
    hold_w.e = eop_out;
    rst_prev = rst;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [6:0] s, input bit so, input bit eo);
    bit done;
    int n;
    valid_in = 1'b1;
    data_in  = s;
    sop_in   = so;
    eop_in   = eo;
    done = 0;
    n = 0;
    while (!done) begin
      @(negedge clk);
      done = ready_out;
      n++;
      @(posedge clk);
      #1;
      if (!done && n > 500) begin
        chk("send_timeout", 32'(n), 32'd0);
        done = 1;
      end
    end
    valid_in = 1'b0;
    sop_in   = 1'b0;
    eop_in   = 1'b0;
    data_in  = '0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic clear_log();
    log_d.delete();
    log_s.delete();
    log_e.delete();
    log_c.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    rst = 1'b1;
    idle(3);
    chk("init_valid", 32'(valid_out), 32'd0);
    chk("init_data", data_out, 32'd0);
    chk("init_sop_err", 32'(sop_err), 32'd0);
    rst = 1'b0;
    idle(2);

    // sop+eop single symbol.
    clear_log();
    send(7'h55, 1, 1);
    idle(3);
    chk("t1_count", 32'(log_d.size()), 32'd1);
    if (log_d.size() >= 1) begin
      chk("t1_data", log_d[0], 32'h0000_0055);
      chk("t1_sop", 32'(log_s[0]), 32'd1);
      chk("t1_eop", 32'(log_e[0]), 32'd1);
      chk("t1_latency", 32'(log_c[0] - last_acc_cyc), 32'd1);
    end

    // 32 symbols 0..31: exact fill, no flush.
    clear_log();
    saw_block = 0;
    for (int k = 0; k < 32; k++) send(7'(k), k == 0, k == 31);
    idle(3);
    chk("t2_count", 32'(log_d.size()), 32'd7);
    chk("t2_no_flush", 32'(saw_block), 32'd0);
    if (log_d.size() == 7) begin
      chk("t2_word0", log_d[0], 32'h4060_8080);
      chk("t2_word6", log_d[6], 32'h3E78_E9C3);
      chk("t2_sop0", 32'(log_s[0]), 32'd1);
      chk("t2_eop0", 32'(log_e[0]), 32'd0);
      chk("t2_sop6", 32'(log_s[6]), 32'd0);
      chk("t2_eop6", 32'(log_e[6]), 32'd1);
    end

    // 5 x 7F: full word then 3-bit flush residue.
    clear_log();
    saw_block = 0;
    for (int k = 0; k < 5; k++) send(7'h7F, k == 0, k == 4);
    idle(3);
    chk("t3_flush_block", 32'(saw_block), 32'd1);
    chk("t3_count", 32'(log_d.size()), 32'd2);
    if (log_d.size() == 2) begin
      chk("t3_word0", log_d[0], 32'hFFFF_FFFF);
      chk("t3_eop0", 32'(log_e[0]), 32'd0);
      chk("t3_word1", log_d[1], 32'h0000_0007);
      chk("t3_eop1", 32'(log_e[1]), 32'd1);
      chk("t3_sop1", 32'(log_s[1]), 32'd0);
    end

    // Backpressure with a pending word.
    clear_log();
    rdy_val = 0;
    idle(1);
    for (int k = 0; k < 5; k++) send(7'h01, k == 0, 0);
    fork
      send(7'h01, 0, 1);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("t4_valid", 32'(valid_out), 32'd1);
          chk("t4_data", data_out, 32'h1020_4081);
          chk("t4_sop", 32'(sop_out), 32'd1);
          chk("t4_ready_out", 32'(ready_out), 32'd0);
        end
        rdy_val = 1;
      end
    join
    idle(4);
    chk("t4_count", 32'(log_d.size()), 32'd2);
    if (log_d.size() == 2) begin
      chk("t4_word0", log_d[0], 32'h1020_4081);
      chk("t4_word1", log_d[1], 32'h0000_0008);
      chk("t4_eop1", 32'(log_e[1]), 32'd1);
    end

    // Symbol without sop in IDLE.
    clear_log();
    send(7'h33, 0, 0);
    chk("t5_sop_err", 32'(sop_err), 32'd1);
    chk("t5_no_valid", 32'(valid_out), 32'd0);
    idle(1);
    chk("t5_sop_err_pulse", 32'(sop_err), 32'd0);
    send(7'h2A, 1, 1);
    idle(3);
    chk("t5_count", 32'(log_d.size()), 32'd1);
    if (log_d.size() == 1) chk("t5_word", log_d[0], 32'h0000_002A);

    // Reset mid-packet, then a fresh 4-symbol packet.
    clear_log();
    for (int k = 0; k < 3; k++) send(7'h7F, k == 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_valid", 32'(valid_out), 32'd0);
    chk("t6_data", data_out, 32'd0);
    chk("t6_sop_err", 32'(sop_err), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) send(7'h7F, k == 0, k == 3);
    idle(3);
    chk("t6_count", 32'(log_d.size()), 32'd1);
    if (log_d.size() == 1) begin
      chk("t6_word", log_d[0], 32'h0FFF_FFFF);
      chk("t6_sop", 32'(log_s[0]), 32'd1);
      chk("t6_eop", 32'(log_e[0]), 32'd1);
    end

    // Randomised packets against the model.
    rdy_rand = 1;
    for (int p = 0; p < 150; p++) begin
      if ($urandom_range(0, 9) == 0) send(7'($urandom), 0, 0);
      case (p % 8)
        0:       len = 32;
        1:       len = 5;
        default: len = $urandom_range(1, 40);
      endcase
      for (int k = 0; k < len; k++) begin
        send(7'($urandom), (k == 0) || ($urandom_range(0, 19) == 0), k == len - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        if ($urandom_range(0, 199) == 0) pulse_reset();
      end
    end
    rdy_rand = 0;
    rdy_val = 1;
    idle(20);
    chk("drained", 32'(expq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
